fetch_unit: RTL

- Instruction-fetch front end of the multicycle/pipelined MIPS core. It is the consumer side of the branch unit's redirect interface.
- Holds the fetch PC and issues single-outstanding requests to instruction memory.
- Loads the IR/PC pair that decode and branch logic read.
- Applies `pcjump`/`real_pc` redirects and inserts NOP bubbles when `ir_bubble` is asserted.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 84 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect/bubble controls, instruction-memory handshake and IR/PC outputs of the fetch unit.
interface fetch_unit_if;
    logic        pcjump;
    logic [31:0] real_pc;
    logic        ir_bubble;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;

    modport slave (
        input  pcjump, real_pc, ir_bubble, stall, imem_valid, imem_rdata,
        output imem_req, imem_addr, ir, pc, ir_valid
    );

    modport master (
        output pcjump, real_pc, ir_bubble, stall, imem_valid, imem_rdata,
        input  imem_req, imem_addr, ir, pc, ir_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect, bubble, stall and a 1-entry word buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fbuf_q, fbuf_d;
    logic        ir_valid_q, ir_valid_d;
    logic        got;
    logic        load;

    assign got  = (state_q == REQ) && bus.imem_valid;
    assign load = got || (state_q == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            ir_q       <= NOP_WORD;
            pc_q       <= RESET_PC;
            fbuf_q     <= NOP_WORD;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            fbuf_q     <= fbuf_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        fbuf_d     = fbuf_q;
        ir_valid_d = ir_valid_q;
        if (bus.pcjump) begin
            fetch_pc_d = bus.real_pc;
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
            // an outstanding request must be drained before the new address is issued
            state_d    = ((state_q == REQ || state_q == DRAIN) && !bus.imem_valid) ? DRAIN : REQ;
        end else if (bus.ir_bubble || bus.stall) begin
            if (bus.ir_bubble) begin
                ir_d       = NOP_WORD;
                ir_valid_d = 1'b0;
            end
            if (got) begin
                fbuf_d  = bus.imem_rdata;
                state_d = HOLD;
            end else if (state_q == IDLE || (state_q == DRAIN && bus.imem_valid)) begin
                state_d = REQ;
            end
        end else if (load) begin
            ir_d       = (state_q == HOLD) ? fbuf_q : bus.imem_rdata;
            pc_d       = fetch_pc_q;
            ir_valid_d = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = REQ;
        end else begin
            ir_d       = (state_q == IDLE) ? ir_q : NOP_WORD;
            ir_valid_d = (state_q == IDLE) ? ir_valid_q : 1'b0;
            state_d    = (state_q == DRAIN && !bus.imem_valid) ? DRAIN : REQ;
        end
    end

    assign bus.imem_req  = (state_q == REQ);
    assign bus.imem_addr = fetch_pc_q;
    assign bus.ir        = ir_q;
    assign bus.pc        = pc_q;
    assign bus.ir_valid  = ir_valid_q;
endmodule
